regfile_alu_engine: RTL
=======================

// Module: regfile_alu_engine
// PURPOSE
//  Parametrised successor of the lab FSM/regfile/LFSR/ALU datapath, in one block.
//  - A control FSM fills an NREG x WIDTH register file with LFSR values.
//  - It then runs button-selected ALU ops over a rotating pointer: R[p+2] <= R[p] op R[p+1].
//  - Each result goes to the display path with a one-cycle valid strobe.
//  - Sits between the debounced board buttons and the 7-seg/LED drivers.
// PARAMETERS
//  WIDTH      16        datapath/register/LFSR width, >=4
//  NREG       32        register count, power of 2, >=4
//  LFSR_TAPS  16'hB400  Galois tap mask, WIDTH bits
//  LFSR_SEED  16'h0001  LFSR reset value; 0 is forced to 1
// PORTS
//  clk        in   1              single clock
//  rst        in   1              synchronous, active-high reset
//  op_btn     in   4              debounced op buttons; bit i selects op i
//  mode_btn   in   1              debounced button; restarts fill
//  busy       out  1              high whenever state != WAIT_OP
//  state_o    out  2              FILL=0, WAIT_OP=1, EXEC=2, WRITE=3 (LEDs)
//  ptr_o      out  $clog2(NREG)   current rotating pointer p
//  disp_data  out  WIDTH          last result written
//  disp_valid out  1              one-cycle strobe, new disp_data
//  dbg_addr   in   $clog2(NREG)   debug read address
//  dbg_data   out  WIDTH          combinational R[dbg_addr]
// BEHAVIOUR
//  Reset (rst=1 at a clock edge), regardless of current state:
//   - state=FILL, fill_ptr=0, p=0, lfsr=LFSR_SEED, disp_data=0, disp_valid=0.
//   - Button history regs are set to all-ones, so a button held through reset makes no edge.
//  Edge detection: press = btn & ~btn_q, sampled every cycle; presses while busy are dropped, not queued.
//  LFSR step: lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_TAPS : lfsr>>1; it advances only on fill writes.
//  FILL: each cycle R[fill_ptr] <= lfsr, then lfsr steps and fill_ptr++.
//   - After writing R[NREG-1], go to WAIT_OP; fill takes exactly NREG cycles.
//   - A mode press during FILL restarts at fill_ptr=0; the LFSR is not reseeded.
//  WAIT_OP:
//   - mode press: go to FILL (fill_ptr=0, LFSR not reseeded); it wins over a simultaneous op press.
//   - exactly one op_btn bit pressed: latch op=index, go to EXEC.
//   - zero or more than one op bit pressed: stay in WAIT_OP.
//  EXEC: res_q <= ALU(R[p], R[p+1]), indices mod NREG. Ops:
//   - 0 ADD, 1 SUB (R[p]-R[p+1]), 2 AND, 3 OR; all truncated mod 2^WIDTH.
//  WRITE:
//   - R[(p+2) mod NREG] <= res_q; disp_data <= res_q; disp_valid <= 1.
//   - p <= p+1 mod NREG; go to WAIT_OP.
//  Latency: press detected at edge t -> EXEC at t+1 -> WRITE at t+2 -> disp_valid=1 for exactly cycle t+3.
//   - Next press is accepted at edge t+3.
//  Wrap: p=NREG-2 writes R[0]; p=NREG-1 reads R[NREG-1], R[0] and writes R[1].
//  Reset mid-EXEC/WRITE: the pending write is discarded; the array is refilled by FILL.
// CONFIGURATION
//  ALU_FLAGS_EN defined:
//   - Adds output flags[3:0] = {N,Z,C,V}, registered in WRITE alongside disp_data; reset 0.
//   - N = res msb; Z = (res==0).
//   - C: ADD carry-out; SUB = 1 when no borrow (A>=B unsigned); 0 for AND/OR.
//   - V: signed overflow for ADD/SUB; 0 for AND/OR.
//  ALU_FLAGS_EN undefined: no flags port and no flag logic; all other behaviour identical.
// TESTING (WIDTH=16, NREG=4, defaults)
//  1. Release rst, run 4 cycles.
//     -> dbg_data R0..R3 = 0001, B400, 5A00, 2D00; state_o=1; busy=0.
//  2. op_btn=0001 pulse.
//     -> R2 = B401; disp_data = B401; disp_valid high exactly 1 cycle at t+3; ptr_o=1.
//  3. op_btn=0010.
//     -> R3 = B400-B401 = FFFF; ptr_o=2; flags = N1 Z0 C0 V0 (with ALU_FLAGS_EN).
//  4. op_btn=0011 (two bits), and a press while busy.
//     -> no state change, no disp_valid, no register write.
//  5. Ops at p=2 and p=3 (AND, OR).
//     -> p=2 writes R0, p=3 reads R3,R0 and writes R1; ptr_o wraps to 0.
//  6. mode_btn + op_btn same cycle -> FILL, R0 = 1680. rst asserted during EXEC -> state_o=0 next cycle, disp_valid never pulses.

Source files
------------

// File: rtl/regfile_alu_engine.sv
// Button-driven regfile/LFSR/ALU datapath: FILL loads the array from a Galois LFSR,
// then each op press computes R[p+2] <= R[p] op R[p+1]. Optional macro: ALU_FLAGS_EN.
module regfile_alu_engine #(
    parameter int               WIDTH     = 16,
    parameter int               NREG      = 32,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] LFSR_SEED = 16'h0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              op_btn,
    input  logic                    mode_btn,
    output logic                    busy,
    output logic [1:0]              state_o,
    output logic [$clog2(NREG)-1:0] ptr_o,
    output logic [WIDTH-1:0]        disp_data,
    output logic                    disp_valid,
`ifdef ALU_FLAGS_EN
    output logic [3:0]              flags,
`endif
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [WIDTH-1:0]        dbg_data
);
    localparam int AW = $clog2(NREG);
    localparam logic [WIDTH-1:0] SEED = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {FILL = 2'd0, WAIT_OP = 2'd1, EXEC = 2'd2, WRITE = 2'd3} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] regs [NREG];
    logic [AW-1:0]    fill_ptr_reg, p_reg, p_inc1, p_inc2;
    logic [WIDTH-1:0] lfsr_reg, lfsr_next, res_reg;
    logic [1:0]       op_reg, op_idx;
    logic [3:0]       op_btn_q, op_press;
    logic             mode_btn_q, mode_press;
    logic             fill_restart, op_accept;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;

    assign op_press   = op_btn & ~op_btn_q;
    assign mode_press = mode_btn & ~mode_btn_q;
    assign p_inc1     = p_reg + AW'(1);
    assign p_inc2     = p_reg + AW'(2);
    assign lfsr_next  = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);

    assign busy     = (state_reg != WAIT_OP);
    assign state_o  = state_reg;
    assign ptr_o    = p_reg;
    assign dbg_data = regs[dbg_addr];

    always_comb begin
        op_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (op_press[i]) op_idx = 2'(i);
        end
    end

    // Mode press always wins; a restart cycle writes nothing and rewinds fill_ptr.
    always_comb begin
        state_next   = state_reg;
        fill_restart = 1'b0;
        op_accept    = 1'b0;
        case (state_reg)
            FILL: begin
                if (mode_press) fill_restart = 1'b1;
                else if (fill_ptr_reg == AW'(NREG - 1)) state_next = WAIT_OP;
            end
            WAIT_OP: begin
                if (mode_press) begin
                    fill_restart = 1'b1;
                    state_next   = FILL;
                end else if ($onehot(op_press)) begin
                    op_accept  = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = WRITE;
            WRITE:   state_next = WAIT_OP;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        alu_a = regs[p_reg];
        alu_b = regs[p_inc1];
        case (op_reg)
            2'd0:    alu_res = alu_a + alu_b;
            2'd1:    alu_res = alu_a - alu_b;
            2'd2:    alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    // Single write port shared by FILL and WRITE.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = fill_ptr_reg;
        wr_data = lfsr_reg;
        if (state_reg == FILL && !fill_restart) begin
            wr_en = 1'b1;
        end else if (state_reg == WRITE) begin
            wr_en   = 1'b1;
            wr_addr = p_inc2;
            wr_data = res_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) regs[wr_addr] <= wr_data;
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_next, flags_pend_reg;
    logic       a_msb, b_msb, r_msb, flag_c, flag_v;

    always_comb begin
        a_msb  = alu_a[WIDTH-1];
        b_msb  = alu_b[WIDTH-1];
        r_msb  = alu_res[WIDTH-1];
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op_reg)
            2'd0: begin
                flag_c = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~r_msb);
                flag_v = (a_msb == b_msb) && (r_msb != a_msb);
            end
            2'd1: begin
                flag_c = (alu_a >= alu_b);
                flag_v = (a_msb != b_msb) && (r_msb != a_msb);
            end
            default: ;
        endcase
        flags_next = {r_msb, (alu_res == '0), flag_c, flag_v};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_pend_reg <= '0;
            flags          <= '0;
        end else begin
            if (state_reg == EXEC)  flags_pend_reg <= flags_next;
            if (state_reg == WRITE) flags          <= flags_pend_reg;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            fill_ptr_reg <= '0;
            p_reg        <= '0;
            lfsr_reg     <= SEED;
            disp_data    <= '0;
            disp_valid   <= 1'b0;
            op_btn_q     <= '1;
            mode_btn_q   <= 1'b1;
            op_reg       <= '0;
            res_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            op_btn_q   <= op_btn;
            mode_btn_q <= mode_btn;
            disp_valid <= 1'b0;
            if (fill_restart) begin
                fill_ptr_reg <= '0;
            end else if (state_reg == FILL) begin
                fill_ptr_reg <= fill_ptr_reg + AW'(1);
                lfsr_reg     <= lfsr_next;
            end
            if (op_accept) op_reg <= op_idx;
            if (state_reg == EXEC) res_reg <= alu_res;
            if (state_reg == WRITE) begin
                disp_data  <= res_reg;
                disp_valid <= 1'b1;
                p_reg      <= p_inc1;
            end
        end
    end
endmodule
